// File: rtl/fifo_flag_ctrl.sv
// FIFO flag/control stage: gates pointer-counter enables, tracks occupancy,
// drives full/empty/almost flags and sticky overflow/underflow/pointer errors.
module fifo_flag_ctrl #(
  parameter int DEPTH  = 256,
  parameter int AF_LVL = 240,
  parameter int AE_LVL = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       WR_REQ,
  input  logic       RD_REQ,
  input  logic [7:0] WR_Q,
  input  logic [7:0] RD_Q,
  output logic       WR_CE,
  output logic       RD_CE,
  output logic       FULL,
  output logic       EMPTY,
  output logic       ALMOST_FULL,
  output logic       ALMOST_EMPTY,
  output logic       OVERFLOW,
  output logic       UNDERFLOW,
  output logic       PTR_ERR,
  output logic [8:0] COUNT
);

  localparam logic [8:0] DEPTH_C = 9'(DEPTH);
  localparam logic [8:0] AF_C    = 9'(AF_LVL);
  localparam logic [8:0] AE_C    = 9'(AE_LVL);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [8:0] count_nxt;
  logic [7:0] ptr_diff;

  assign WR_CE    = WR_REQ & ~FULL & ~CLR;
  assign RD_CE    = RD_REQ & ~EMPTY & ~CLR;
  assign ptr_diff = WR_Q - RD_Q;

  always_comb begin
    count_nxt = COUNT;
    unique case ({WR_CE, RD_CE})
      2'b10:   count_nxt = COUNT + 9'd1;
      2'b01:   count_nxt = COUNT - 9'd1;
      default: count_nxt = COUNT;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_EMPTY: begin
        if (WR_CE)
          state_nxt = (DEPTH == 1) ? S_FULL : S_PARTIAL;
      end
      S_PARTIAL: begin
        if (count_nxt == 9'd0)
          state_nxt = S_EMPTY;
        else if (count_nxt == DEPTH_C)
          state_nxt = S_FULL;
      end
      S_FULL: begin
        if (RD_CE)
          state_nxt = S_PARTIAL;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Pointer check sees the Q values and COUNT from the same prior update.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state        <= S_EMPTY;
      COUNT        <= 9'd0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
      PTR_ERR      <= 1'b0;
    end else begin
      state        <= state_nxt;
      COUNT        <= count_nxt;
      FULL         <= (state_nxt == S_FULL);
      EMPTY        <= (state_nxt == S_EMPTY);
      ALMOST_FULL  <= (count_nxt >= AF_C);
      ALMOST_EMPTY <= (count_nxt <= AE_C);
      OVERFLOW     <= OVERFLOW | (WR_REQ & FULL);
      UNDERFLOW    <= UNDERFLOW | (RD_REQ & EMPTY);
      PTR_ERR      <= PTR_ERR | (ptr_diff != COUNT[7:0]);
    end
  end

endmodule
